// File: rtl/psu_pwrgd_seq_fsm.sv
// Per-rail PSU on/off sequencer timed by an external 1 ms tick counter.
// Times the power-good wait, the debounce and the off delay, and latches faults.
module psu_pwrgd_seq_fsm #(
  parameter int TIMEOUT_MS   = 100,
  parameter int DEBOUNCE_MS  = 2,
  parameter int OFF_DELAY_MS = 10
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iPsuOnReq,
  input  logic       iPwrgd,
  input  logic       iTick,
  input  logic       iFaultClr,
  output logic       oTimerEn,
  output logic       oPsuEn,
  output logic       oPsuOk,
  output logic       oFault,
  output logic [1:0] oFaultCode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PG,
    S_DEBOUNCE,
    S_ON,
    S_OFF_WAIT,
    S_FAULT
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_TOUT = 2'b01;
  localparam logic [1:0] FC_LOST = 2'b10;
  localparam logic [1:0] FC_PRE  = 2'b11;

  localparam logic [7:0] TO_CNT  = 8'(TIMEOUT_MS);
  localparam logic [7:0] DB_CNT  = 8'(DEBOUNCE_MS);
  localparam logic [7:0] OFF_CNT = 8'(OFF_DELAY_MS);

  state_t     state;
  state_t     nxt;
  logic [1:0] nxt_code;
  logic [7:0] cnt;
  logic       chg;
  logic       nxt_timed;
  logic       nxt_en;

  always_comb begin
    nxt      = state;
    nxt_code = oFaultCode;
    unique case (state)
      S_IDLE: begin
        if (iPsuOnReq && iPwrgd) begin
          nxt      = S_FAULT;
          nxt_code = FC_PRE;
        end else if (iPsuOnReq) begin
          nxt = S_WAIT_PG;
        end
      end
      S_WAIT_PG: begin
        if (!iPsuOnReq) begin
          nxt = S_OFF_WAIT;
        end else if (iPwrgd) begin
          nxt = S_DEBOUNCE;
        end else if (cnt == TO_CNT) begin
          nxt      = S_FAULT;
          nxt_code = FC_TOUT;
        end
      end
      S_DEBOUNCE: begin
        if (!iPsuOnReq) begin
          nxt = S_OFF_WAIT;
        end else if (!iPwrgd) begin
          nxt = S_WAIT_PG;
        end else if (cnt == DB_CNT) begin
          nxt = S_ON;
        end
      end
      S_ON: begin
        // a turn-off request masks a simultaneous pwrgd drop
        if (!iPsuOnReq) begin
          nxt = S_OFF_WAIT;
        end else if (!iPwrgd) begin
          nxt      = S_FAULT;
          nxt_code = FC_LOST;
        end
      end
      S_OFF_WAIT: begin
        if (cnt == OFF_CNT) begin
          nxt = S_IDLE;
        end
      end
      S_FAULT: begin
        if (iFaultClr && !iPsuOnReq) begin
          nxt      = S_OFF_WAIT;
          nxt_code = FC_NONE;
        end
      end
      default: begin
        nxt      = S_IDLE;
        nxt_code = FC_NONE;
      end
    endcase
  end

  assign chg       = (nxt != state);
  assign nxt_timed = (nxt == S_WAIT_PG)
                  || (nxt == S_DEBOUNCE)
                  || (nxt == S_OFF_WAIT);
  assign nxt_en    = (nxt == S_WAIT_PG)
                  || (nxt == S_DEBOUNCE)
                  || (nxt == S_ON);

  // timer enable stays low for one cycle after every state change
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      oTimerEn   <= 1'b0;
      oPsuEn     <= 1'b0;
      oPsuOk     <= 1'b0;
      oFault     <= 1'b0;
      oFaultCode <= FC_NONE;
    end else begin
      state <= nxt;
      if (chg) begin
        cnt <= 8'd0;
      end else if (iTick && oTimerEn && cnt != 8'hff) begin
        cnt <= cnt + 8'd1;
      end
      oTimerEn   <= nxt_timed && !chg;
      oPsuEn     <= nxt_en;
      oPsuOk     <= (nxt == S_ON);
      oFault     <= (nxt == S_FAULT);
      oFaultCode <= nxt_code;
    end
  end

endmodule

// File: tb/tb_psu_pwrgd_seq_fsm.sv
// Directed bench for the PSU power-good sequencer.
// Ticks are issued every 20 cycles while the timer enable is high.
module tb_psu_pwrgd_seq_fsm;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       pwrgd;
  logic       tick;
  logic       clr;
  logic       timer_en;
  logic       psu_en;
  logic       psu_ok;
  logic       fault;
  logic [1:0] code;

  int npass = 0;
  int ntot = 0;
  int n_ticks = 0;
  int pc = 0;
  bit saw_en = 0;
  bit saw_fault = 0;

  psu_pwrgd_seq_fsm #(
    .TIMEOUT_MS  (5),
    .DEBOUNCE_MS (2),
    .OFF_DELAY_MS(3)
  ) dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iPsuOnReq (req),
    .iPwrgd    (pwrgd),
    .iTick     (tick),
    .iFaultClr (clr),
    .oTimerEn  (timer_en),
    .oPsuEn    (psu_en),
    .oPsuOk    (psu_ok),
    .oFault    (fault),
    .oFaultCode(code)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin : tick_gen
    tick = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick) n_ticks++;
      if (timer_en === 1'b1) begin
        pc++;
        if (pc == 20) begin
          tick = 1;
          pc = 0;
        end else begin
          tick = 0;
        end
      end else begin
        pc = 0;
        tick = 0;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (psu_en === 1'b1) saw_en = 1;
      if (fault === 1'b1) saw_fault = 1;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic apply_reset;
    rst_n = 0;
    req = 0;
    pwrgd = 0;
    clr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_ticks(input int n, input string tag);
    int target;
    int b;
    target = n_ticks + n;
    b = 0;
    while (n_ticks < target && b < n * 25 + 20) begin
      @(negedge clk);
      b++;
    end
    if (n_ticks < target) begin
      ntot++;
      $display("FAIL %s: tick wait expired, got %0d want %0d", tag, n_ticks, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    req = 0;
    pwrgd = 0;
    clr = 0;
    #1;
    ntot++; if (psu_en !== 1'b0) $display("FAIL rst_en got %b want 0", psu_en); else npass++;
    ntot++; if (timer_en !== 1'b0) $display("FAIL rst_ten got %b want 0", timer_en); else npass++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ntot++; if (psu_ok !== 1'b0) $display("FAIL rst_ok got %b want 0", psu_ok); else npass++;
    ntot++; if (fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fault); else npass++;
    ntot++; if (code !== 2'b00) $display("FAIL rst_code got %b want 00", code); else npass++;
  endtask

  task automatic test_nominal;
    apply_reset;
    saw_fault = 0;
    req = 1;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b1) $display("FAIL t1_en got %b want 1", psu_en); else npass++;
    ntot++; if (timer_en !== 1'b0) $display("FAIL t1_ten0 got %b want 0", timer_en); else npass++;
    @(negedge clk);
    ntot++; if (timer_en !== 1'b1) $display("FAIL t1_ten1 got %b want 1", timer_en); else npass++;
    wait_ticks(2, "t1_wait");
    ntot++; if (psu_ok !== 1'b0) $display("FAIL t1_ok_wait got %b want 0", psu_ok); else npass++;
    pwrgd = 1;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b1) $display("FAIL t1_en_deb got %b want 1", psu_en); else npass++;
    wait_ticks(2, "t1_deb");
    ntot++; if (psu_ok !== 1'b0) $display("FAIL t1_ok_early got %b want 0", psu_ok); else npass++;
    @(negedge clk);
    ntot++; if (psu_ok !== 1'b1) $display("FAIL t1_ok got %b want 1", psu_ok); else npass++;
    req = 0;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b0) $display("FAIL t1_off_en got %b want 0", psu_en); else npass++;
    ntot++; if (psu_ok !== 1'b0) $display("FAIL t1_off_ok got %b want 0", psu_ok); else npass++;
    wait_ticks(3, "t1_off");
    ntot++; if (timer_en !== 1'b1) $display("FAIL t1_offw got %b want 1", timer_en); else npass++;
    @(negedge clk);
    ntot++; if (timer_en !== 1'b0) $display("FAIL t1_idle got %b want 0", timer_en); else npass++;
    ntot++; if (saw_fault !== 1'b0) $display("FAIL t1_nofault got %b want 0", saw_fault); else npass++;
    pwrgd = 0;
  endtask

  task automatic test_timeout;
    apply_reset;
    req = 1;
    @(negedge clk);
    wait_ticks(5, "t2_to");
    ntot++; if (fault !== 1'b0) $display("FAIL t2_early got %b want 0", fault); else npass++;
    ntot++; if (psu_en !== 1'b1) $display("FAIL t2_en_pre got %b want 1", psu_en); else npass++;
    @(negedge clk);
    ntot++; if (fault !== 1'b1) $display("FAIL t2_fault got %b want 1", fault); else npass++;
    ntot++; if (code !== 2'b01) $display("FAIL t2_code got %b want 01", code); else npass++;
    ntot++; if (psu_en !== 1'b0) $display("FAIL t2_en got %b want 0", psu_en); else npass++;
    ntot++; if (timer_en !== 1'b0) $display("FAIL t2_ten got %b want 0", timer_en); else npass++;
    clr = 1;
    @(negedge clk);
    clr = 0;
    repeat (2) @(negedge clk);
    ntot++; if (fault !== 1'b1) $display("FAIL t2_latch got %b want 1", fault); else npass++;
    ntot++; if (code !== 2'b01) $display("FAIL t2_latch_code got %b want 01", code); else npass++;
  endtask

  task automatic test_glitch;
    apply_reset;
    saw_fault = 0;
    req = 1;
    @(negedge clk);
    wait_ticks(1, "t3_w1");
    pwrgd = 1;
    @(negedge clk);
    ntot++; if (timer_en !== 1'b0) $display("FAIL t3_deb_ten got %b want 0", timer_en); else npass++;
    wait_ticks(1, "t3_d1");
    pwrgd = 0;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b1) $display("FAIL t3_back_en got %b want 1", psu_en); else npass++;
    ntot++; if (timer_en !== 1'b0) $display("FAIL t3_back_ten got %b want 0", timer_en); else npass++;
    wait_ticks(4, "t3_w4");
    @(negedge clk);
    ntot++; if (fault !== 1'b0) $display("FAIL t3_fresh got %b want 0", fault); else npass++;
    pwrgd = 1;
    @(negedge clk);
    wait_ticks(2, "t3_d2");
    ntot++; if (psu_ok !== 1'b0) $display("FAIL t3_ok_early got %b want 0", psu_ok); else npass++;
    @(negedge clk);
    ntot++; if (psu_ok !== 1'b1) $display("FAIL t3_ok got %b want 1", psu_ok); else npass++;
    ntot++; if (saw_fault !== 1'b0) $display("FAIL t3_nofault got %b want 0", saw_fault); else npass++;
  endtask

  task automatic test_pg_loss;
    apply_reset;
    req = 1;
    @(negedge clk);
    pwrgd = 1;
    @(negedge clk);
    wait_ticks(2, "t4_d");
    @(negedge clk);
    ntot++; if (psu_ok !== 1'b1) $display("FAIL t4_on got %b want 1", psu_ok); else npass++;
    pwrgd = 0;
    @(negedge clk);
    ntot++; if (fault !== 1'b1) $display("FAIL t4_fault got %b want 1", fault); else npass++;
    ntot++; if (code !== 2'b10) $display("FAIL t4_code got %b want 10", code); else npass++;
    ntot++; if (psu_en !== 1'b0) $display("FAIL t4_en got %b want 0", psu_en); else npass++;
    req = 0;
    clr = 1;
    @(negedge clk);
    clr = 0;
    ntot++; if (fault !== 1'b0) $display("FAIL t4_clr got %b want 0", fault); else npass++;
    ntot++; if (code !== 2'b00) $display("FAIL t4_clr_code got %b want 00", code); else npass++;
    wait_ticks(3, "t4_off");
    ntot++; if (timer_en !== 1'b1) $display("FAIL t4_offw got %b want 1", timer_en); else npass++;
    @(negedge clk);
    ntot++; if (timer_en !== 1'b0) $display("FAIL t4_idle got %b want 0", timer_en); else npass++;
    saw_fault = 0;
    req = 1;
    @(negedge clk);
    pwrgd = 1;
    @(negedge clk);
    wait_ticks(2, "t4_d2");
    @(negedge clk);
    ntot++; if (psu_ok !== 1'b1) $display("FAIL t4_on2 got %b want 1", psu_ok); else npass++;
    req = 0;
    pwrgd = 0;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b0) $display("FAIL t4_sim_en got %b want 0", psu_en); else npass++;
    repeat (5) @(negedge clk);
    ntot++; if (saw_fault !== 1'b0) $display("FAIL t4_sim_fault got %b want 0", saw_fault); else npass++;
    ntot++; if (timer_en !== 1'b1) $display("FAIL t4_sim_offw got %b want 1", timer_en); else npass++;
  endtask

  task automatic test_pre_enable;
    apply_reset;
    saw_en = 0;
    pwrgd = 1;
    repeat (2) @(negedge clk);
    ntot++; if (fault !== 1'b0) $display("FAIL t5_idle got %b want 0", fault); else npass++;
    req = 1;
    @(negedge clk);
    ntot++; if (fault !== 1'b1) $display("FAIL t5_fault got %b want 1", fault); else npass++;
    ntot++; if (code !== 2'b11) $display("FAIL t5_code got %b want 11", code); else npass++;
    repeat (3) @(negedge clk);
    ntot++; if (saw_en !== 1'b0) $display("FAIL t5_never_en got %b want 0", saw_en); else npass++;
  endtask

  task automatic test_reset_mid;
    apply_reset;
    req = 1;
    @(negedge clk);
    pwrgd = 1;
    @(negedge clk);
    repeat (25) @(negedge clk);
    ntot++; if (psu_en !== 1'b1) $display("FAIL t6_pre_en got %b want 1", psu_en); else npass++;
    ntot++; if (psu_ok !== 1'b0) $display("FAIL t6_pre_ok got %b want 0", psu_ok); else npass++;
    #2;
    rst_n = 0;
    #1;
    ntot++; if (psu_en !== 1'b0) $display("FAIL t6_async_en got %b want 0", psu_en); else npass++;
    ntot++; if (timer_en !== 1'b0) $display("FAIL t6_async_ten got %b want 0", timer_en); else npass++;
    req = 0;
    pwrgd = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b0) $display("FAIL t6_idle_en got %b want 0", psu_en); else npass++;
    req = 1;
    @(negedge clk);
    ntot++; if (psu_en !== 1'b1) $display("FAIL t6_req_en got %b want 1", psu_en); else npass++;
    wait_ticks(5, "t6_to");
    @(negedge clk);
    ntot++; if (code !== 2'b01) $display("FAIL t6_waitpg got %b want 01", code); else npass++;
  endtask

  initial begin
    rst_n = 0;
    req = 0;
    pwrgd = 0;
    clr = 0;
    test_reset;
    test_nominal;
    test_timeout;
    test_glitch;
    test_pg_loss;
    test_pre_enable;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
